// File: rtl/mac_pkg.sv
// Shared constants and helpers for the pipelined multiply-accumulate block.
// Saturation is selected by defining PIPELINED_MAC_SATURATE_EN.
package mac_pkg;

    localparam int DEF_DATA_W     = 4;
    localparam int DEF_ACC_W      = 16;
    localparam int DEF_MUL_STAGES = 2;

    function automatic int prod_w(input int data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/mac_mul_pipe.sv
// Unsigned multiplier followed by a STAGES-deep register chain.
// Each stage carries a valid and last flag; the whole chain holds while en is low.
module mac_mul_pipe
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int STAGES = DEF_MUL_STAGES,
    localparam int PW    = prod_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              last,
    output logic              out_valid,
    output logic [PW-1:0]     prod,
    output logic              out_last
);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] l_q;
    logic [PW-1:0]     p_q [STAGES];
    logic [PW-1:0]     p_d;

    assign p_d = PW'(a) * PW'(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            l_q <= '0;
        end else if (flush) begin
            v_q <= '0;
        end else if (en) begin
            v_q[0] <= in_valid;
            l_q[0] <= last;
            for (int i = 1; i < STAGES; i++) begin
                v_q[i] <= v_q[i-1];
                l_q[i] <= l_q[i-1];
            end
        end
    end

    // Product data is qualified by v_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            p_q[0] <= p_d;
            for (int i = 1; i < STAGES; i++) begin
                p_q[i] <= p_q[i-1];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_last  = l_q[STAGES-1];
    assign prod      = p_q[STAGES-1];

endmodule

// File: rtl/pipelined_mac.sv
// Pipelined MAC: multiply pipe, accumulate stage, held output register.
// Define PIPELINED_MAC_SATURATE_EN to clamp overflowed sums instead of wrapping.
module pipelined_mac
    import mac_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int MUL_STAGES = DEF_MUL_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              last,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf
);

    localparam int PW = prod_w(DATA_W);

    logic             m_v;
    logic             m_last;
    logic [PW-1:0]    m_prod;
    logic             stall;
    logic             load;

    logic             acc_v_q;
    logic             acc_last_q;
    logic             grp_start_q;
    logic [ACC_W-1:0] sum_q;
    logic             sum_ovf_q;
    logic [ACC_W-1:0] sum_d;
    logic             sum_ovf_d;
    logic [ACC_W-1:0] base;
    logic             base_ovf;
    logic [ACC_W:0]   add;

    logic             out_valid_q;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;

    // A finished group waiting behind an unconsumed result freezes everything.
    assign stall    = out_valid_q && !out_ready && acc_v_q && acc_last_q;
    assign in_ready = rst_n && !clr && !stall;
    assign load     = acc_v_q && acc_last_q && !stall;

    mac_mul_pipe #(
        .DATA_W (DATA_W),
        .STAGES (MUL_STAGES)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (!stall),
        .flush     (clr),
        .in_valid  (in_valid && in_ready),
        .a         (a),
        .b         (b),
        .last      (last),
        .out_valid (m_v),
        .prod      (m_prod),
        .out_last  (m_last)
    );

    always_comb begin
        base      = grp_start_q ? '0 : sum_q;
        base_ovf  = grp_start_q ? 1'b0 : sum_ovf_q;
        add       = {1'b0, base} + (ACC_W+1)'(m_prod);
        sum_ovf_d = base_ovf | add[ACC_W];
`ifdef PIPELINED_MAC_SATURATE_EN
        sum_d     = sum_ovf_d ? '1 : add[ACC_W-1:0];
`else
        sum_d     = add[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_v_q     <= 1'b0;
            acc_last_q  <= 1'b0;
            grp_start_q <= 1'b1;
            sum_q       <= '0;
            sum_ovf_q   <= 1'b0;
        end else if (clr) begin
            acc_v_q     <= 1'b0;
            acc_last_q  <= 1'b0;
            grp_start_q <= 1'b1;
            sum_q       <= '0;
            sum_ovf_q   <= 1'b0;
        end else if (!stall) begin
            acc_v_q <= m_v;
            if (m_v) begin
                acc_last_q  <= m_last;
                grp_start_q <= m_last;
                sum_q       <= sum_d;
                sum_ovf_q   <= sum_ovf_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
        end else if (clr) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            acc_q       <= sum_q;
            ovf_q       <= sum_ovf_q;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_mac.sv
// Randomised and directed bench for pipelined_mac against a group-sum model.
// Honours PIPELINED_MAC_SATURATE_EN for the expected overflow behaviour.
module tb_pipelined_mac;

    localparam int DATA_W = 4;
    localparam int ACC_W  = 16;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic             ovf;
    } res_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              last;
    logic              clr;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  acc_out;
    logic              ovf;

    int n_chk  = 0;
    int n_pass = 0;

    res_t             expq[$];
    longint unsigned  gsum;
    logic             have_hold;
    logic [ACC_W-1:0] hold_acc;
    logic             hold_ovf;
    logic             saw_stall;

    always #5 clk = ~clk;

    pipelined_mac #(
        .DATA_W     (DATA_W),
        .ACC_W      (ACC_W),
        .MUL_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .last      (last),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovf       (ovf)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic flush_model();
        expq.delete();
        gsum      = 0;
        have_hold = 1'b0;
    endtask

    task automatic model_accept(input int av, input int bv,
                                input logic lv);
        longint unsigned lim;
        res_t r;
        gsum += longint'(av * bv);
        if (lv) begin
            lim   = 64'd1 << ACC_W;
            r.ovf = (gsum >= lim);
`ifdef PIPELINED_MAC_SATURATE_EN
            r.acc = r.ovf ? ACC_W'(lim - 1) : ACC_W'(gsum);
`else
            r.acc = ACC_W'(gsum % lim);
`endif
            expq.push_back(r);
            gsum = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            flush_model();
        end else begin
            if (have_hold) begin
                check("hold_v", 32'(out_valid), 1);
                check("hold_acc", 32'(acc_out), 32'(hold_acc));
                check("hold_ovf", 32'(ovf), 32'(hold_ovf));
            end
            if (clr) begin
                check("clr_rdy", 32'(in_ready), 0);
                flush_model();
            end else begin
                if (in_valid && in_ready)
                    model_accept(int'(a), int'(b), last);
                if (in_valid && !in_ready)
                    saw_stall = 1'b1;
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        check("spurious", 1, 0);
                    end else begin
                        res_t e;
                        e = expq.pop_front();
                        check("res", 32'(acc_out), 32'(e.acc));
                        check("res_ovf", 32'(ovf), 32'(e.ovf));
                    end
                end
                have_hold = out_valid && !out_ready;
                hold_acc  = acc_out;
                hold_ovf  = ovf;
            end
        end
    end

    task automatic send(input int av, input int bv, input logic lv,
                        output int tries);
        logic ok;
        in_valid = 1'b1;
        a        = DATA_W'(av);
        b        = DATA_W'(bv);
        last     = lv;
        tries    = 0;
        ok       = 1'b0;
        do begin
            @(negedge clk);
            ok = in_ready;
            tries++;
            @(posedge clk);
            #1;
        end while (!ok && tries < 200);
        in_valid = 1'b0;
        last     = 1'b0;
        if (!ok) check("send_to", 0, 1);
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((expq.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("drain_to", 1, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        last      = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b1;
        saw_stall = 1'b0;
        flush_model();
        #3;
        check("rst_v", 32'(out_valid), 0);
        check("rst_acc", 32'(acc_out), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_rdy", 32'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_rdy", 32'(in_ready), 1);

        // single pair latency
        send(3, 2, 1'b1, t);
        lat = 0;
        check("lat0_v", 32'(out_valid), 0);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 3);
        check("single_acc", 32'(acc_out), 6);
        check("single_ovf", 32'(ovf), 0);
        drain();

        // back-to-back groups without bubbles
        send(5, 7, 1'b0, t);
        check("b2b_rdy0", t, 1);
        send(9, 9, 1'b0, t);
        check("b2b_rdy1", t, 1);
        send(15, 15, 1'b1, t);
        check("b2b_rdy2", t, 1);
        send(8, 8, 1'b0, t);
        check("b2b_rdy3", t, 1);
        send(12, 5, 1'b1, t);
        check("b2b_rdy4", t, 1);
        drain();

        // back-pressure: stall must appear and lose nothing
        saw_stall = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 9; i++)
                    send($urandom_range(0, 15), $urandom_range(0, 15),
                         (i % 3) == 2, t);
            end
            begin
                repeat (14) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("saw_stall", 32'(saw_stall), 1);

        // long group overflowing the accumulator
        for (int i = 0; i < 300; i++)
            send(15, 15, i == 299, t);
        drain();

        // clr mid-group, alongside in_valid
        send(4, 4, 1'b0, t);
        send(6, 6, 1'b0, t);
        in_valid = 1'b1;
        a        = 4'd9;
        b        = 4'd9;
        last     = 1'b1;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        last     = 1'b0;
        check("clr_v", 32'(out_valid), 0);
        send(3, 2, 1'b1, t);
        drain();

        // async reset while a result is pending
        out_ready = 1'b0;
        send(7, 3, 1'b1, t);
        send(2, 2, 1'b0, t);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("pend_v", 32'(out_valid), 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_v", 32'(out_valid), 0);
        check("arst_acc", 32'(acc_out), 0);
        check("arst_ovf", 32'(ovf), 0);
        check("arst_rdy", 32'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(1, 1, 1'b0, t);
        send(2, 3, 1'b1, t);
        drain();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = DATA_W'($urandom_range(0, 15));
            b         = DATA_W'($urandom_range(0, 15));
            last      = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 59) == 0);
            @(posedge clk);
            #1;
        end
        clr  = 1'b0;
        last = 1'b0;
        drain();
        check("end_q", expq.size(), 0);
        check("end_v", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
